// File: rtl/fcl_layer_sched.sv
`default_nettype none
// ============================================================================
// Module   : fcl_layer_sched
// Purpose  : Group-wise sequencer for a fully-connected layer over NUM_PE PEs;
//            optional ReLU on the output stream when FCL_SCHED_RELU_EN is defined.
// Revision : 1.0
// ============================================================================
module fcl_layer_sched #(
    parameter  int IN_LEN    = 16,
    parameter  int OUT_LEN   = 8,
    parameter  int NUM_PE    = 4,
    parameter  int ACC_WIDTH = 15,
    localparam int NUM_GRP   = (OUT_LEN + NUM_PE - 1) / NUM_PE,
    localparam int GRP_W     = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1,
    localparam int IDX_W     = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        layer_start,
    output logic                        pe_start,
    output logic [GRP_W-1:0]            pe_group,
    input  logic [NUM_PE-1:0]           pe_done_vec,
    input  logic [ACC_WIDTH*NUM_PE-1:0] pe_result_flat,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ACC_WIDTH-1:0]        out_data,
    output logic [IDX_W-1:0]            out_idx,
    output logic                        busy,
    output logic                        layer_done
);

    localparam int LANE_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

    if (IN_LEN < 1 || OUT_LEN < 1 || NUM_PE < 1 || OUT_LEN > 65536) begin : g_param_check
        $error("fcl_layer_sched: invalid parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [GRP_W-1:0]       r_group;
    logic [GRP_W-1:0]       w_group_nxt;
    logic [LANE_W-1:0]      r_k;
    logic [LANE_W-1:0]      w_k_nxt;
    logic                   w_capture;
    logic [ACC_WIDTH-1:0]   r_buf [NUM_PE];

    logic                   r_pe_start;
    logic                   r_busy;
    logic                   r_out_valid;
    logic                   r_layer_done;
    logic [ACC_WIDTH-1:0]   r_out_data;
    logic [IDX_W-1:0]       r_out_idx;

    logic [31:0]            w_base;
    logic [NUM_PE-1:0]      w_mask;
    logic                   w_last_lane;
    logic                   w_last_grp;
    logic [ACC_WIDTH-1:0]   w_sel;
    logic [ACC_WIDTH-1:0]   w_out_val;
    logic [IDX_W-1:0]       w_idx_nxt;

    // Row arithmetic is done in 32 bits so OUT_LEN up to 2^16 cannot wrap.
    assign w_base     = 32'(r_group) * 32'(NUM_PE);
    assign w_last_grp = (r_group == GRP_W'(NUM_GRP - 1));
    assign w_last_lane = (32'(r_k) == 32'(NUM_PE - 1)) ||
                         ((w_base + 32'(r_k) + 32'd1) >= 32'(OUT_LEN));

    always_comb begin
        w_mask = '0;
        for (int p = 0; p < NUM_PE; p++) begin
            w_mask[p] = (w_base + 32'(p)) < 32'(OUT_LEN);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_group_nxt = r_group;
        w_k_nxt     = r_k;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (layer_start) begin
                    w_state_nxt = S_ISSUE;
                    w_group_nxt = '0;
                    w_k_nxt     = '0;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // Inactive lanes are masked out so a short last group never stalls.
                if ((pe_done_vec & w_mask) == w_mask) begin
                    w_capture   = 1'b1;
                    w_k_nxt     = '0;
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_out_valid && out_ready) begin
                    if (w_last_lane) begin
                        w_k_nxt = '0;
                        if (w_last_grp) begin
                            w_state_nxt = S_DONE;
                        end else begin
                            w_group_nxt = r_group + GRP_W'(1);
                            w_state_nxt = S_ISSUE;
                        end
                    end else begin
                        w_k_nxt = r_k + LANE_W'(1);
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_group_nxt = '0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_group_nxt = '0;
                w_k_nxt     = '0;
            end
        endcase
    end

    // On the capture edge the buffer is not yet loaded, so lane 0 is taken from the PE bus.
    assign w_sel     = w_capture ? pe_result_flat[0 +: ACC_WIDTH] : r_buf[w_k_nxt];
    assign w_idx_nxt = IDX_W'(32'(w_group_nxt) * 32'(NUM_PE) + 32'(w_k_nxt));

`ifdef FCL_SCHED_RELU_EN
    assign w_out_val = w_sel[ACC_WIDTH-1] ? '0 : w_sel;
`else
    assign w_out_val = w_sel;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_group      <= '0;
            r_k          <= '0;
            r_pe_start   <= 1'b0;
            r_busy       <= 1'b0;
            r_out_valid  <= 1'b0;
            r_layer_done <= 1'b0;
            r_out_data   <= '0;
            r_out_idx    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_group      <= w_group_nxt;
            r_k          <= w_k_nxt;
            r_pe_start   <= (w_state_nxt == S_ISSUE);
            r_busy       <= (w_state_nxt != S_IDLE);
            r_out_valid  <= (w_state_nxt == S_DRAIN);
            r_layer_done <= (w_state_nxt == S_DONE);
            if (w_state_nxt == S_DRAIN) begin
                r_out_data <= w_out_val;
                r_out_idx  <= w_idx_nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < NUM_PE; p++) begin
                r_buf[p] <= '0;
            end
        end else if (w_capture) begin
            for (int p = 0; p < NUM_PE; p++) begin
                r_buf[p] <= pe_result_flat[p*ACC_WIDTH +: ACC_WIDTH];
            end
        end
    end

    assign pe_start   = r_pe_start;
    assign pe_group   = r_group;
    assign busy       = r_busy;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_idx    = r_out_idx;
    assign layer_done = r_layer_done;

endmodule
`default_nettype wire

// File: tb/tb_fcl_layer_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_fcl_layer_sched
// Purpose  : Randomized self-checking bench; full layer (OUT_LEN=8) and partial
//            last group (OUT_LEN=6) instances run side by side.
// Revision : 1.0
// ============================================================================
module tb_fcl_layer_sched;

    localparam int IN_LEN    = 16;
    localparam int NUM_PE    = 4;
    localparam int ACC_WIDTH = 15;
    localparam logic [ACC_WIDTH-1:0] NEG5 = 15'h7FFB;
`ifdef FCL_SCHED_RELU_EN
    localparam logic [ACC_WIDTH-1:0] RELU_NEG = 15'h0000;
`else
    localparam logic [ACC_WIDTH-1:0] RELU_NEG = 15'h7FFB;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [ACC_WIDTH-1:0] exp_out(input logic [ACC_WIDTH-1:0] v);
`ifdef FCL_SCHED_RELU_EN
        return v[ACC_WIDTH-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    for (genvar d = 0; d < 2; d++) begin : g_dut
        localparam int OUT_LEN = (d == 0) ? 8 : 6;
        localparam int NUM_GRP = (OUT_LEN + NUM_PE - 1) / NUM_PE;
        localparam int GRP_W   = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1;
        localparam int IDX_W   = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;
        // ISSUE + WAIT(IN_LEN+1) per group, plus one cycle per transfer.
        localparam int LAT     = NUM_GRP * (IN_LEN + 2) + OUT_LEN;

        logic                        reset;
        logic                        layer_start;
        logic                        pe_start;
        logic [GRP_W-1:0]            pe_group;
        logic [NUM_PE-1:0]           pe_done_vec;
        logic [ACC_WIDTH*NUM_PE-1:0] pe_result_flat;
        logic                        out_valid;
        logic                        out_ready;
        logic [ACC_WIDTH-1:0]        out_data;
        logic [IDX_W-1:0]            out_idx;
        logic                        busy;
        logic                        layer_done;

        fcl_layer_sched #(
            .IN_LEN   (IN_LEN),
            .OUT_LEN  (OUT_LEN),
            .NUM_PE   (NUM_PE),
            .ACC_WIDTH(ACC_WIDTH)
        ) u_dut (
            .clk           (clk),
            .reset         (reset),
            .layer_start   (layer_start),
            .pe_start      (pe_start),
            .pe_group      (pe_group),
            .pe_done_vec   (pe_done_vec),
            .pe_result_flat(pe_result_flat),
            .out_valid     (out_valid),
            .out_ready     (out_ready),
            .out_data      (out_data),
            .out_idx       (out_idx),
            .busy          (busy),
            .layer_done    (layer_done)
        );

        bit                   fin       = 1'b0;
        bit                   fixed_lat = 1'b1;
        int                   res_mode  = 0;
        int                   n_layers  = 0;
        int                   dones     = 0;
        int                   rem      [NUM_PE];
        logic [ACC_WIDTH-1:0] lane_val [NUM_PE];
        logic [ACC_WIDTH-1:0] exp_res  [OUT_LEN];

        // PE bank model: done rises a chosen number of edges after the start edge,
        // result bus carries garbage until then; inactive lanes never report done.
        always @(posedge clk or negedge reset) begin
            if (!reset) begin
                pe_done_vec    <= '0;
                pe_result_flat <= '0;
                for (int p = 0; p < NUM_PE; p++) rem[p] <= 0;
            end else begin
                for (int p = 0; p < NUM_PE; p++) begin
                    if (pe_start) begin
                        pe_done_vec[p] <= 1'b0;
                        rem[p]         <= fixed_lat ? IN_LEN : int'($urandom_range(1, IN_LEN + 4));
                        lane_val[p]    <= (res_mode == 1) ? ((p % 2 == 0) ? NEG5 : 15'd7)
                                                          : ACC_WIDTH'($urandom);
                        pe_result_flat[p*ACC_WIDTH +: ACC_WIDTH] <= ACC_WIDTH'($urandom);
                    end else if (rem[p] == 1) begin
                        rem[p] <= 0;
                        pe_result_flat[p*ACC_WIDTH +: ACC_WIDTH] <= lane_val[p];
                        if (int'(pe_group) * NUM_PE + p < OUT_LEN) begin
                            pe_done_vec[p] <= 1'b1;
                            exp_res[int'(pe_group) * NUM_PE + p] <= lane_val[p];
                        end
                    end else if (rem[p] > 1) begin
                        rem[p] <= rem[p] - 1;
                    end
                end
            end
        end

        // Stream scoreboard: neurons must appear in index order, once each.
        initial begin
            int                   exp_idx;
            int                   nst;
            bit                   stalled;
            bit                   prev_done;
            logic [IDX_W-1:0]     hold_idx;
            logic [ACC_WIDTH-1:0] hold_data;
            exp_idx = 0; nst = 0; stalled = 0; prev_done = 0;
            hold_idx = '0; hold_data = '0;
            forever begin
                @(negedge clk);
                if (!reset) begin
                    exp_idx = 0; nst = 0; stalled = 0; prev_done = 0;
                end else begin
                    if (pe_start) begin
                        check_val("group_at_start", pe_group, nst);
                        check_val("drained_before_start", exp_idx, nst * NUM_PE);
                        check_val("busy_at_start", busy, 1);
                        nst++;
                    end
                    if (stalled) begin
                        check_val("stall_valid", out_valid, 1);
                        check_val("stall_idx", out_idx, hold_idx);
                        check_val("stall_data", out_data, hold_data);
                    end
                    if (out_valid) begin
                        if (exp_idx < OUT_LEN) begin
                            check_val("out_idx", out_idx, exp_idx);
                            check_val("out_data", out_data, exp_out(exp_res[exp_idx]));
                            if (res_mode == 1)
                                check_val("relu_data", out_data, (exp_idx % 2 == 0) ? RELU_NEG : 15'd7);
                        end else begin
                            check_val("extra_transfer", exp_idx, OUT_LEN - 1);
                        end
                        stalled   = !out_ready;
                        hold_idx  = out_idx;
                        hold_data = out_data;
                        if (out_ready) exp_idx++;
                    end else begin
                        stalled = 0;
                    end
                    if (layer_done) begin
                        check_val("done_pulse_width", prev_done, 0);
                        check_val("done_all_sent", exp_idx, OUT_LEN);
                        check_val("done_groups", nst, NUM_GRP);
                        dones++;
                        exp_idx = 0;
                        nst     = 0;
                    end
                    prev_done = layer_done;
                end
            end
        end

        task automatic check_rst(input string w);
            check_val({w, "_pe_start"}, pe_start, 0);
            check_val({w, "_pe_group"}, pe_group, 0);
            check_val({w, "_busy"}, busy, 0);
            check_val({w, "_out_valid"}, out_valid, 0);
            check_val({w, "_out_data"}, out_data, 0);
            check_val({w, "_out_idx"}, out_idx, 0);
            check_val({w, "_layer_done"}, layer_done, 0);
        endtask

        // rmode: 0 ready held high, 1 pattern 1,0,0 repeating, 2 random.
        task automatic run_layer(input int rmode, input bit fixed, input int rres,
                                 input bit pulse_wait, input bit pulse_done,
                                 input int abort_at, input bit chk_lat);
            int edges;
            bit timed_out;
            fixed_lat = fixed;
            res_mode  = rres;
            layer_start = 1'b1;
            @(posedge clk); #1;
            layer_start = 1'b0;
            check_val("start_pe_start", pe_start, 1);
            check_val("start_busy", busy, 1);
            check_val("start_group", pe_group, 0);
            edges = 0;
            timed_out = 0;
            while (1) begin
                case (rmode)
                    0:       out_ready = 1'b1;
                    1:       out_ready = (edges % 3 == 0);
                    default: out_ready = 1'($urandom_range(0, 1));
                endcase
                @(posedge clk); edges++; #1;
                layer_start = pulse_wait && (edges == 5);
                if (abort_at > 0 && edges == abort_at) begin
                    #2 reset = 1'b0;
                    #1 check_rst("abort");
                    @(posedge clk); #1;
                    reset = 1'b1;
                    return;
                end
                if (layer_done) break;
                if (edges >= 3000) begin
                    timed_out = 1;
                    break;
                end
            end
            if (timed_out) begin
                check_val("layer_timeout", edges, 0);
                return;
            end
            n_layers++;
            if (chk_lat) check_val("done_latency", edges, LAT);
            layer_start = pulse_done;
            @(posedge clk); #1;
            layer_start = 1'b0;
            out_ready   = 1'b1;
            check_val("idle_busy", busy, 0);
            check_val("idle_group", pe_group, 0);
            check_val("done_count", dones, n_layers);
            repeat (2) begin
                @(posedge clk); #1;
                check_val("no_restart", pe_start, 0);
            end
        endtask

        initial begin
            reset       = 1'b0;
            layer_start = 1'b0;
            out_ready   = 1'b1;
            repeat (3) @(posedge clk);
            #1 check_rst("por");
            reset = 1'b1;
            @(posedge clk); #1;
            run_layer(0, 1, 0, 0, 0, 0,  1);
            run_layer(1, 0, 0, 0, 0, 0,  0);
            run_layer(2, 1, 1, 0, 0, 0,  0);
            run_layer(0, 1, 0, 1, 1, 0,  1);
            run_layer(0, 1, 0, 0, 0, 30, 0);
            run_layer(0, 1, 0, 0, 0, 0,  1);
            for (int i = 0; i < 4; i++) run_layer(2, 0, 0, 0, 0, 0, 0);
            fin = 1'b1;
        end
    end

    initial begin
        while (!(g_dut[0].fin && g_dut[1].fin) && cyc < 20000) @(posedge clk);
        if (!(g_dut[0].fin && g_dut[1].fin)) check_val("global_timeout", cyc, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
